// File: rtl/mw_pipe_stage.sv
// -----------------------------------------------------------------------------
// mw_pipe_stage
// Pipeline stage register with a per-entry valid bit, a valid/ready handshake
// and a 2-entry skid buffer (main M + skid S). in_ready comes straight from a
// flop, so out_ready never reaches in_ready combinationally. Flush kills both
// entries and turns them into bubbles. Used at the F/D, D/E, E/M and M/W
// boundaries.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   synchronous kill of both stored entries
//   in_valid   in   upstream presents an entry
//   in_ready   out  stage can accept (registered, equals ~S.valid)
//   in_ctrl    in   upstream control bits [CTRL_W]
//   in_data    in   upstream payload [DATA_W]
//   in_pc      in   upstream PC [PC_W]
//   out_valid  out  main register holds a live entry
//   out_ready  in   downstream accepts
//   out_ctrl   out  control bits, all-zero whenever out_valid=0
//   out_data   out  payload (don't-care when out_valid=0)
//   out_pc     out  PC (don't-care when out_valid=0)
// -----------------------------------------------------------------------------
module mw_pipe_stage #(
    parameter int unsigned          CTRL_W   = 4,
    parameter int unsigned          DATA_W   = 69,
    parameter int unsigned          PC_W     = 32,
    parameter logic [PC_W-1:0]      RESET_PC = PC_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc
);

    // One stored pipeline entry.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_entry_c;
    logic   in_ready_q, in_ready_d;
    logic   xfer_in_c;
    logic   xfer_out_c;

    // Handshake qualifiers.
    assign xfer_in_c  = in_valid & in_ready_q;
    assign xfer_out_c = m_q.valid & out_ready;

    // Incoming entry as it would be stored.
    assign in_entry_c = '{valid: 1'b1, ctrl: in_ctrl, data: in_data, pc: in_pc};

    // Next-state for M, S and in_ready.
    always_comb begin
        m_d = m_q;
        s_d = s_q;

        if (flush) begin
            // Entries become bubbles; data/pc keep their last values.
            m_d.valid = 1'b0;
            m_d.ctrl  = '0;
            s_d.valid = 1'b0;
            s_d.ctrl  = '0;
        end else if (!m_q.valid || xfer_out_c) begin
            if (s_q.valid) begin
                // Skid drains first to keep FIFO order.
                m_d       = s_q;
                s_d.valid = 1'b0;
                if (xfer_in_c) begin
                    s_d = in_entry_c;
                end
            end else if (xfer_in_c) begin
                m_d = in_entry_c;
            end else begin
                m_d.valid = 1'b0;
                m_d.ctrl  = '0;
            end
        end else if (xfer_in_c) begin
            // M is stalled: the one extra entry parks in S.
            s_d = in_entry_c;
        end

        in_ready_d = ~s_d.valid;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q        <= '{valid: 1'b0, ctrl: '0, data: '0, pc: RESET_PC};
            s_q        <= '{valid: 1'b0, ctrl: '0, data: '0, pc: RESET_PC};
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Outputs come from M only; ctrl is masked so a bubble never writes.
    assign in_ready  = in_ready_q;
    assign out_valid = m_q.valid;
    assign out_ctrl  = m_q.ctrl & {CTRL_W{m_q.valid}};
    assign out_data  = m_q.data;
    assign out_pc    = m_q.pc;

    // Structural invariants of the skid pair.
    a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
        s_q.valid |-> m_q.valid);
    a_ready_tracks_skid: assert property (@(posedge clk) disable iff (reset)
        in_ready_q == ~s_q.valid);

endmodule

// File: tb/tb_mw_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_mw_pipe_stage
// Self-checking bench for mw_pipe_stage. A queue-based reference (at most two
// entries, popped on transfer out, pushed on accepted transfer in, cleared on
// flush/reset) predicts every output each cycle. Directed phases cover reset,
// streaming, stall/skid, flush at occupancy 2 and a bubble; then random
// traffic with ~5% flush.
// -----------------------------------------------------------------------------
module tb_mw_pipe_stage;

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned DATA_W = 69;
    localparam int unsigned PC_W   = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;

    mw_pipe_stage #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_pc   (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Compare all outputs with the reference queue.
    task automatic check_outputs();
        logic [CTRL_W-1:0] exp_ctrl;
        exp_ctrl = (mq.size() > 0) ? mq[0].ctrl : '0;
        check_eq("in_ready",  128'(in_ready),  128'(mq.size() < 2));
        check_eq("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        check_eq("out_ctrl",  128'(out_ctrl),  128'(exp_ctrl));
        if (mq.size() > 0) begin
            check_eq("out_pc",   128'(out_pc),   128'(mq[0].pc));
            check_eq("out_data", 128'(out_data), 128'(mq[0].data));
        end
    endtask

    // Drive one cycle, advance the reference, then check after the edge.
    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic [PC_W-1:0] pc, input logic ordy);
        bit   can_take;
        ent_t e;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        in_pc     = pc;
        out_ready = ordy;
        can_take  = (mq.size() < 2);
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && ordy) mq.delete(0);
            if (iv && can_take) begin
                e.ctrl = c;
                e.data = d;
                e.pc   = pc;
                mq.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [PC_W-1:0]   next_pc;
        logic              have;
        logic [CTRL_W-1:0] p_ctrl;
        logic [DATA_W-1:0] p_data;
        logic [PC_W-1:0]   p_pc;
        logic              iv;
        logic              fl;
        logic              ordy;
        bit                pre_rdy;

        // Reset held two cycles with input offered.
        cyc(1'b1, 1'b0, 1'b1, 4'hF, rnd_data(), 32'h1234, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 4'hF, rnd_data(), 32'h1238, 1'b1);
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_ctrl",  128'(out_ctrl),  128'(0));
        check_eq("rst_out_pc",    128'(out_pc),    128'(32'h3000));
        check_eq("rst_out_data",  128'(out_data),  128'(0));
        check_eq("rst_in_ready",  128'(in_ready),  128'(1));

        // Streaming: each PC appears one cycle after acceptance.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 4'b0011, rnd_data(), 32'h3000 + 32'(4 * i), 1'b1);
            check_eq("stream_pc",    128'(out_pc),   128'(32'h3000 + 32'(4 * i)));
            check_eq("stream_ready", 128'(in_ready), 128'(1));
        end
        cyc(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
        check_eq("stream_drained", 128'(out_valid), 128'(0));

        // Stall/skid: 0x3004 parks in S while 0x3000 is held on the output.
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, rnd_data(), 32'h3000, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, rnd_data(), 32'h3004, 1'b0);
        check_eq("skid_ready_low", 128'(in_ready), 128'(0));
        check_eq("skid_hold_pc",   128'(out_pc),   128'(32'h3000));
        p_data = rnd_data();
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, p_data, 32'h3008, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, p_data, 32'h3008, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, p_data, 32'h3008, 1'b1);
        check_eq("skid_drain_pc", 128'(out_pc),   128'(32'h3004));
        check_eq("skid_ready_hi", 128'(in_ready), 128'(1));
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, p_data, 32'h3008, 1'b1);
        check_eq("skid_last_pc", 128'(out_pc), 128'(32'h3008));
        cyc(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1);

        // Flush at occupancy 2 together with a new input.
        cyc(1'b0, 1'b0, 1'b1, 4'b0100, rnd_data(), 32'h3020, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0100, rnd_data(), 32'h3024, 1'b0);
        check_eq("fl_full", 128'(in_ready), 128'(0));
        cyc(1'b0, 1'b1, 1'b1, 4'b0100, rnd_data(), 32'h3010, 1'b0);
        check_eq("fl_out_valid", 128'(out_valid), 128'(0));
        check_eq("fl_out_ctrl",  128'(out_ctrl),  128'(0));
        check_eq("fl_in_ready",  128'(in_ready),  128'(1));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
            check_eq("fl_no_3010", 128'(out_valid), 128'(0));
        end

        // Bubble mid-stream.
        for (int i = 0; i < 5; i++) begin
            iv = (i != 2);
            cyc(1'b0, 1'b0, iv, 4'b1011, rnd_data(), 32'h3100 + 32'(4 * i), 1'b1);
            if (i == 2) begin
                check_eq("bub_valid", 128'(out_valid), 128'(0));
                check_eq("bub_ctrl",  128'(out_ctrl),  128'(0));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1);

        // Random traffic; upstream holds an offered entry until it is taken.
        next_pc = 32'h4000;
        have    = 1'b0;
        p_ctrl  = '0;
        p_pc    = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!have) begin
                p_ctrl  = CTRL_W'($urandom());
                p_data  = rnd_data();
                p_pc    = next_pc;
                next_pc = next_pc + 32'd4;
                have    = 1'b1;
            end
            iv      = ($urandom_range(0, 3) != 0);
            fl      = ($urandom_range(0, 99) < 5);
            ordy    = ($urandom_range(0, 9) < 7);
            pre_rdy = (mq.size() < 2);
            cyc(1'b0, fl, iv, p_ctrl, p_data, p_pc, ordy);
            if (iv && (pre_rdy || fl)) have = 1'b0;
        end

        // Reset mid-stream with S full.
        cyc(1'b0, 1'b0, 1'b1, 4'hF, rnd_data(), 32'h5000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'hF, rnd_data(), 32'h5004, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'hF, rnd_data(), 32'h5008, 1'b0);
        check_eq("mrst_pc",    128'(out_pc),   128'(32'h3000));
        check_eq("mrst_data",  128'(out_data), 128'(0));
        check_eq("mrst_ready", 128'(in_ready), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
